// File: rtl/shift_divider.sv
// shift_divider: serial divide-by-2^k with remainder, logical or arithmetic (floor) mode
module shift_divider #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             sout,
  output logic             sout_valid
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SHW-1:0] KMAX = SHW'(WIDTH);
  state_t state;
  logic [WIDTH-1:0] sr, rem;
  logic [SHW-1:0] cnt, step, k;
  logic smode;
  assign k = (shamt > KMAX) ? KMAX : shamt;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  assign quotient = sr;
  assign remainder = rem;
  // control FSM and datapath: load on start, shift one bit per enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      rem <= '0;
      cnt <= '0;
      step <= '0;
      smode <= 1'b0;
      sout <= 1'b0;
      sout_valid <= 1'b0;
    end else begin
      sout_valid <= 1'b0;
      if (state != SHIFT && start) begin
        sr <= data;
        rem <= '0;
        cnt <= k;
        step <= '0;
        smode <= signed_mode;
        state <= (k != '0) ? SHIFT : DONE;
      end else if (state == SHIFT && enable) begin
        sr <= {smode & sr[WIDTH-1], sr[WIDTH-1:1]};
        rem <= rem | (WIDTH'(sr[0]) << step);
        sout <= sr[0];
        sout_valid <= 1'b1;
        step <= step + SHW'(1);
        cnt <= cnt - SHW'(1);
        if (cnt == SHW'(1)) state <= DONE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_shift_divider.sv
// tb_shift_divider: randomized scoreboard bench for shift_divider against an arithmetic model
module tb_shift_divider;
  logic clk = 0, rst = 1, start = 0, enable = 0, signed_mode = 0;
  logic [7:0] data = 0;
  logic [3:0] shamt = 0;
  logic busy, done, sout, sout_valid;
  logic [7:0] quotient, remainder;
  int vectors = 0, miscompares = 0;
  typedef struct {logic [7:0] q; logic [7:0] r; int k;} exp_t;
  exp_t sb[$];
  logic bits[$];

  shift_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .data(data),
    .shamt(shamt), .signed_mode(signed_mode), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .sout(sout), .sout_valid(sout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input logic [3:0] s, input logic sm);
    exp_t e;
    int k, p, v, q;
    k = (s > 8) ? 8 : int'(s);
    p = 1 << k;
    v = sm ? int'($signed(d)) : int'(d);
    q = v / p;
    if (v < 0 && (v % p) != 0) q = q - 1;
    e.q = q[7:0];
    e.r = 8'(int'(d) % p);
    e.k = k;
    return e;
  endfunction

  // monitor: collect streamed bits, check each result against the scoreboard head
  always @(negedge clk) begin
    if (rst) bits.delete();
    else begin
      if (sout_valid) bits.push_back(sout);
      if (busy && done) chk("busy_with_done", 1, 0);
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          int obs;
          e = sb.pop_front();
          obs = 0;
          foreach (bits[i]) obs = obs | (int'(bits[i]) << i);
          chk("quotient", int'(quotient), int'(e.q));
          chk("remainder", int'(remainder), int'(e.r));
          chk("sout_count", bits.size(), e.k);
          chk("sout_bits", obs, int'(e.r));
        end
        bits.delete();
      end
    end
  end

  // one operation starting in the current cycle; ends in the cycle where done must be high
  task automatic op(input logic [7:0] d, input logic [3:0] s, input logic sm,
                    input bit rnd_en, input int stall_after, input int stall_n, input bit inject);
    int left, k, stalls;
    bit en;
    exp_t e;
    e = model(d, s, sm);
    k = e.k;
    start = 1; data = d; shamt = s; signed_mode = sm; enable = 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 0;
    left = k;
    stalls = 0;
    while (left > 0) begin
      chk("busy_in_shift", int'(busy), 1);
      chk("done_in_shift", int'(done), 0);
      en = rnd_en ? ($urandom_range(0, 3) != 0) : !((k - left) == stall_after && stalls < stall_n);
      if (!en) stalls++;
      enable = en;
      if (inject && left == 2 && en) begin
        start = 1; data = 8'd1; shamt = 4'd1; signed_mode = 0;
      end
      if (en) left--;
      @(posedge clk); #1;
      start = 0;
    end
    enable = 1;
    chk("done_pulse", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_sout", int'(sout), 0);
    chk("rst_sv", int'(sout_valid), 0);
    rst = 0;
    @(posedge clk); #1;
    op(8'd200, 4'd3, 0, 0, 0, 0, 0);
    op(8'd203, 4'd3, 0, 0, 0, 0, 0);
    op(8'hF9, 4'd1, 1, 0, 0, 0, 0);
    op(8'h80, 4'd8, 1, 0, 0, 0, 0);
    op(8'h5A, 4'd0, 0, 0, 0, 0, 0);
    op(8'hA5, 4'd12, 0, 0, 0, 0, 0);
    op(8'd200, 4'd4, 0, 0, 2, 2, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    start = 1; data = 8'hB7; shamt = 4'd5; signed_mode = 0; enable = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_sout", int'(sout), 0);
    chk("abort_sv", int'(sout_valid), 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (8) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", int'(done), 0);
    end
    op(8'd100, 4'd2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      op(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1, 0, 0, 0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
